// File: rtl/pwm_pkg.sv
// Shared types and default constants for the multichannel PWM block.
package pwm_pkg;

  typedef enum logic {
    EDGE   = 1'b0,
    CENTER = 1'b1
  } pwm_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_t;

  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned RST_PERIOD_DEF = 9999;

endpackage

// File: rtl/pwm_multichannel_if.sv
// Control/status bundle between the register block (master) and the PWM generator (slave).
interface pwm_multichannel_if
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned N_CH  = 4
) ();

  logic                   enable;
  logic                   cfg_load;
  logic [CNT_W-1:0]       period_in;
  logic [N_CH*CNT_W-1:0]  duty_in;
  logic                   mode_in;
  logic                   cfg_pending;
  logic                   cyc_start;
  logic [N_CH-1:0]        PWM_out;

  modport master (
    output enable, cfg_load, period_in, duty_in, mode_in,
    input  cfg_pending, cyc_start, PWM_out
  );

  modport slave (
    input  enable, cfg_load, period_in, duty_in, mode_in,
    output cfg_pending, cyc_start, PWM_out
  );

endinterface

// File: rtl/pwm_timebase.sv
// Shared counter for all channels: edge/center sequencing, terminal decode and
// the strobes that move configuration between pending and active registers.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  pwm_mode_t        mode,
  input  logic [CNT_W-1:0] period,
  input  logic             cfg_load,
  input  logic             pend,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o,
  output logic             load_active_o,
  output logic             apply_pend_o,
  output logic             capture_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  pwm_dir_t         dir_q, dir_d;
  logic             at_top;
  logic             term;

  assign at_top = (cnt_q == period);

  // With period 1 in center mode the top is also the last count, so the
  // terminal decode must accept an up-counting 1 as well.
  always_comb begin
    term = 1'b1;
    if (enable) begin
      if (mode == EDGE) begin
        term = at_top;
      end else begin
        term = (period == '0) ||
               ((cnt_q == CNT_ONE) && ((dir_q == DIR_DOWN) || at_top));
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable || term) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (mode == EDGE) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dir_q == DIR_DOWN) begin
      cnt_d = cnt_q - CNT_ONE;
    end else if (at_top) begin
      cnt_d = cnt_q - CNT_ONE;
      dir_d = DIR_DOWN;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign cnt_o         = cnt_q;
  assign term_o        = term;
  assign load_active_o = term & cfg_load;
  assign apply_pend_o  = term & pend & ~cfg_load;
  assign capture_o     = ~term & cfg_load;

endmodule

// File: rtl/pwm_multichannel.sv
// N_CH PWM outputs from one timebase; period, duty and mode are double-buffered
// and swapped only at a period boundary so outputs never glitch.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int unsigned      CNT_W      = CNT_W_DEF,
  parameter int unsigned      N_CH       = 4,
  parameter int unsigned      RST_PERIOD = RST_PERIOD_DEF,
  parameter logic [N_CH-1:0]  POL        = '0
) (
  input  logic              in_10MHz,
  input  logic              RESET,
  pwm_multichannel_if.slave bus
);

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RST_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic             term;
  logic             load_active;
  logic             apply_pend;
  logic             capture;

  logic [CNT_W-1:0] period_a_q, period_a_d;
  logic [CNT_W-1:0] period_p_q, period_p_d;
  pwm_mode_t        mode_a_q, mode_a_d;
  pwm_mode_t        mode_p_q, mode_p_d;
  logic             pend_q, pend_d;
  logic             cyc_start_q;

  pwm_timebase #(
    .CNT_W(CNT_W)
  ) u_timebase (
    .clk          (in_10MHz),
    .rst_n        (RESET),
    .enable       (bus.enable),
    .mode         (mode_a_q),
    .period       (period_a_q),
    .cfg_load     (bus.cfg_load),
    .pend         (pend_q),
    .cnt_o        (cnt),
    .term_o       (term),
    .load_active_o(load_active),
    .apply_pend_o (apply_pend),
    .capture_o    (capture)
  );

  // A load in the terminal cycle bypasses pending and goes straight to active.
  always_comb begin
    period_a_d = period_a_q;
    mode_a_d   = mode_a_q;
    period_p_d = period_p_q;
    mode_p_d   = mode_p_q;
    pend_d     = pend_q;
    if (load_active) begin
      period_a_d = bus.period_in;
      mode_a_d   = pwm_mode_t'(bus.mode_in);
      pend_d     = 1'b0;
    end else if (apply_pend) begin
      period_a_d = period_p_q;
      mode_a_d   = mode_p_q;
      pend_d     = 1'b0;
    end else if (capture) begin
      period_p_d = bus.period_in;
      mode_p_d   = pwm_mode_t'(bus.mode_in);
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge in_10MHz) begin
    if (!RESET) begin
      period_a_q  <= RST_P;
      mode_a_q    <= EDGE;
      period_p_q  <= '0;
      mode_p_q    <= EDGE;
      pend_q      <= 1'b0;
      cyc_start_q <= 1'b0;
    end else begin
      period_a_q  <= period_a_d;
      mode_a_q    <= mode_a_d;
      period_p_q  <= period_p_d;
      mode_p_q    <= mode_p_d;
      pend_q      <= pend_d;
      cyc_start_q <= bus.enable & (cnt == '0);
    end
  end

  assign bus.cfg_pending = pend_q;
  assign bus.cyc_start   = cyc_start_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] duty_in_w;
      logic [CNT_W-1:0] duty_a_q, duty_a_d;
      logic [CNT_W-1:0] duty_p_q, duty_p_d;
      logic             raw;
      logic             pwm_q;

      assign duty_in_w = bus.duty_in[gi*CNT_W +: CNT_W];
      assign raw       = bus.enable & (cnt < duty_a_q);

      always_comb begin
        duty_a_d = duty_a_q;
        duty_p_d = duty_p_q;
        if (load_active) begin
          duty_a_d = duty_in_w;
        end else if (apply_pend) begin
          duty_a_d = duty_p_q;
        end else if (capture) begin
          duty_p_d = duty_in_w;
        end
      end

      always_ff @(posedge in_10MHz) begin
        if (!RESET) begin
          duty_a_q <= '0;
          duty_p_q <= '0;
          pwm_q    <= POL[gi];
        end else begin
          duty_a_q <= duty_a_d;
          duty_p_q <= duty_p_d;
          pwm_q    <= raw ^ POL[gi];
        end
      end

      assign bus.PWM_out[gi] = pwm_q;
    end
  endgenerate

endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboard bench: two instances (32-bit/POL 0 and 8-bit/POL 0101) share stimulus;
// a phase-based reference model predicts every output cycle.
module tb_pwm_multichannel;
  import pwm_pkg::*;

  typedef struct packed {
    logic [3:0] pwm;
    logic       cs;
    logic       cp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic        mode;
  logic [31:0] per;
  logic [31:0] duty [4];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_multichannel_if #(.CNT_W(32), .N_CH(4)) bus_a ();
  pwm_multichannel_if #(.CNT_W(8),  .N_CH(4)) bus_b ();

  assign bus_a.enable    = en;
  assign bus_a.cfg_load  = load;
  assign bus_a.mode_in   = mode;
  assign bus_a.period_in = per;
  assign bus_a.duty_in   = {duty[3], duty[2], duty[1], duty[0]};
  assign bus_b.enable    = en;
  assign bus_b.cfg_load  = load;
  assign bus_b.mode_in   = mode;
  assign bus_b.period_in = per[7:0];
  assign bus_b.duty_in   = {duty[3][7:0], duty[2][7:0], duty[1][7:0], duty[0][7:0]};

  pwm_multichannel #(
    .CNT_W(32), .N_CH(4), .RST_PERIOD(9999), .POL(4'b0000)
  ) dut_a (
    .in_10MHz(clk),
    .RESET   (rst_n),
    .bus     (bus_a)
  );

  pwm_multichannel #(
    .CNT_W(8), .N_CH(4), .RST_PERIOD(200), .POL(4'b0101)
  ) dut_b (
    .in_10MHz(clk),
    .RESET   (rst_n),
    .bus     (bus_b)
  );

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  longint unsigned m_P [2];
  longint unsigned m_D [2][4];
  bit              m_M [2];
  longint unsigned p_P [2];
  longint unsigned p_D [2][4];
  bit              p_M [2];
  bit              m_pend [2];
  longint unsigned m_phase [2];

  exp_t q_a [$];
  exp_t q_b [$];

  function automatic longint unsigned mask_of(int u);
    return (u == 0) ? 64'hFFFF_FFFF : 64'hFF;
  endfunction

  function automatic logic [3:0] pol_of(int u);
    return (u == 0) ? 4'b0000 : 4'b0101;
  endfunction

  function automatic longint unsigned rstp_of(int u);
    return (u == 0) ? 64'd9999 : 64'd200;
  endfunction

  function automatic longint unsigned m_len(int u);
    if (m_P[u] == 0) return 1;
    return m_M[u] ? 2 * m_P[u] : m_P[u] + 1;
  endfunction

  function automatic bit m_term(int u);
    return !en || (m_phase[u] == m_len(u) - 1);
  endfunction

  // Position within the period maps to a count: a ramp in edge mode, a triangle in center mode.
  function automatic exp_t m_step(int u);
    exp_t            e;
    longint unsigned c;
    bit              t;
    longint unsigned pin;
    longint unsigned din [4];
    if (!rst_n) begin
      m_P[u] = rstp_of(u);
      m_M[u] = 1'b0;
      p_P[u] = 0;
      p_M[u] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_D[u][k] = 0;
        p_D[u][k] = 0;
      end
      m_pend[u]  = 1'b0;
      m_phase[u] = 0;
      e.pwm = pol_of(u);
      e.cs  = 1'b0;
      e.cp  = 1'b0;
      return e;
    end
    c = (m_M[u] && m_phase[u] > m_P[u]) ? 2 * m_P[u] - m_phase[u] : m_phase[u];
    if (!en) c = 0;
    for (int k = 0; k < 4; k++) begin
      e.pwm[k] = (en && (c < m_D[u][k])) ^ pol_of(u)[k];
    end
    e.cs = en && (c == 0);
    t    = m_term(u);
    pin  = longint'(per) & mask_of(u);
    for (int k = 0; k < 4; k++) din[k] = longint'(duty[k]) & mask_of(u);
    if (t) begin
      if (load) begin
        m_P[u] = pin;
        m_M[u] = mode;
        for (int k = 0; k < 4; k++) m_D[u][k] = din[k];
        m_pend[u] = 1'b0;
      end else if (m_pend[u]) begin
        m_P[u] = p_P[u];
        m_M[u] = p_M[u];
        for (int k = 0; k < 4; k++) m_D[u][k] = p_D[u][k];
        m_pend[u] = 1'b0;
      end
      m_phase[u] = 0;
    end else begin
      if (load) begin
        p_P[u] = pin;
        p_M[u] = mode;
        for (int k = 0; k < 4; k++) p_D[u][k] = din[k];
        m_pend[u] = 1'b1;
      end
      m_phase[u] = m_phase[u] + 1;
    end
    e.cp = m_pend[u];
    return e;
  endfunction

  always @(posedge clk) begin
    q_a.push_back(m_step(0));
    q_b.push_back(m_step(1));
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      g = {bus_a.PWM_out, bus_a.cyc_start, bus_a.cfg_pending};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL out_a t=%0t got pwm=%b cs=%b cp=%b want pwm=%b cs=%b cp=%b",
                 $time, g.pwm, g.cs, g.cp, e.pwm, e.cs, e.cp);
      end
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      g = {bus_b.PWM_out, bus_b.cyc_start, bus_b.cfg_pending};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL out_b t=%0t got pwm=%b cs=%b cp=%b want pwm=%b cs=%b cp=%b",
                 $time, g.pwm, g.cs, g.cp, e.pwm, e.cs, e.cp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int p, input bit m, input int d0, input int d1,
                         input int d2, input int d3);
    per     = p;
    mode    = m;
    duty[0] = d0;
    duty[1] = d1;
    duty[2] = d2;
    duty[3] = d3;
    load    = 1'b1;
    $display("load t=%0t en=%0b P=%0d mode=%0d D={%0d,%0d,%0d,%0d}", $time, en, p, m, d0, d1, d2, d3);
    tick(1);
    load = 1'b0;
  endtask

  task automatic wait_term();
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_term(0)) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL term_wait got no terminal cycle within 200 cycles, want one");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    load  = 1'b0;
    mode  = 1'b0;
    per   = '0;
    for (int k = 0; k < 4; k++) duty[k] = '0;

    tick(3);
    rst_n = 1'b1;
    en    = 1'b1;
    tick(10010);

    en = 1'b0;
    do_load(9, 0, 0, 3, 10, 5);
    tick(2);
    en = 1'b1;
    tick(40);

    do_load(4, 1, 2, 0, 0, 0);
    tick(40);

    do_load(9, 0, 3, 3, 3, 3);
    tick(25);
    tick(3);
    do_load(19, 0, 7, 1, 19, 20);
    tick(60);

    wait_term();
    do_load(5, 1, 2, 5, 6, 1);
    tick(30);
    tick(3);
    do_load(12, 0, 1, 2, 3, 4);
    do_load(7, 0, 2, 4, 6, 8);
    tick(40);

    tick(5);
    rst_n = 1'b0;
    load  = 1'b1;
    per   = 3;
    tick(1);
    load  = 1'b0;
    rst_n = 1'b1;
    en    = 1'b0;
    tick(10);
    do_load(6, 0, 2, 0, 7, 3);
    en = 1'b1;
    tick(20);

    en = 1'b0;
    do_load(0, 0, 0, 1, 5, 0);
    en = 1'b1;
    tick(10);
    do_load(0, 1, 3, 0, 0, 9);
    tick(10);

    do_load(255, 0, 255, 0, 128, 1);
    tick(600);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        en = 1'b0;
        tick($urandom_range(1, 4));
        en = 1'b1;
      end
      if (it == 20) begin
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
      end
      do_load($urandom_range(0, 40), 1'($urandom_range(0, 1)), $urandom_range(0, 45),
              $urandom_range(0, 45), $urandom_range(0, 45), $urandom_range(0, 45));
      tick($urandom_range(1, 70));
    end

    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised successor to the single-output PWM generator. It drives N_CH PWM outputs from one shared timebase. Period, per-channel duty and alignment mode (edge or center) are runtime-programmable through shadow registers that take effect only at a period boundary, so outputs never glitch. It sits between the control register block and the output pads, clocked from the 10 MHz system clock.

## Interface
- Reset: synchronous, active-low (`RESET`); one clock domain (`in_10MHz`).
- Parameters:
  - `CNT_W`, default 32: timebase and compare width.
  - `N_CH`, default 4: number of PWM channels (1..16).
  - `RST_PERIOD`, default 9999: active period after reset (1 kHz at 10 MHz).
  - `POL`, default 0: N_CH-bit mask; a 1 inverts that channel's output.
- Ports:
  - `in_10MHz`  in  1: clock.
  - `RESET`  in  1: synchronous active-low reset.
  - `enable`  in  1: run the timebase; low = idle.
  - `cfg_load`  in  1: one-cycle strobe that captures `period_in`, `duty_in` and `mode_in` into pending.
  - `period_in`  in  CNT_W: terminal count P.
  - `duty_in`  in  N_CH*CNT_W: duty D[k]; channel k occupies bits [k*CNT_W +: CNT_W].
  - `mode_in`  in  1: 0 = edge-aligned, 1 = center-aligned.
  - `cfg_pending`  out  1: pending set captured but not yet applied.
  - `cyc_start`  out  1: one-cycle pulse aligned with the output cycle for count 0.
  - `PWM_out`  out  N_CH: registered PWM outputs.

## Operation
- State:
  - Counter `cnt` (CNT_W bits).
  - Direction bit `dir` (0 = up).
  - Active registers P_a, D_a[k], M_a.
  - Pending registers P_p, D_p[k], M_p, plus flag `pend`.
- Edge mode: `cnt` runs 0,1,…,P_a, then 0. Period is P_a+1 cycles.
- Center mode: `cnt` runs up 0…P_a, then down P_a−1…1, then 0. Period is 2·P_a cycles.
- P_a = 0 in either mode: `cnt` holds 0 and every cycle is a boundary.
- Terminal cycle, where the next `cnt` is 0:
  - Edge mode: `cnt` == P_a.
  - Center mode: `dir` = 1 and `cnt` == 1, or P_a = 0.
  - Direction flips to down when `cnt` == P_a in center mode, and back to up at the terminal cycle.
- Compare: raw[k] = (`cnt` < D_a[k]).
  - D = 0 gives a constant low.
  - D > P_a gives a constant high (100%).
  - `PWM_out[k]` is registered raw[k] XOR POL[k].
- Shadow update:
  - `cfg_load` writes pending and sets `pend`. A second load before the boundary overwrites pending; the last one wins.
  - In a terminal cycle with `pend` = 1, the active registers take pending and `pend` clears.
  - `cfg_load` in the terminal cycle itself: the input values go straight to active and `pend` stays 0.
- Enable:
  - While `enable` = 0: `cnt` = 0, `dir` = 0, raw forced low, so `PWM_out` = POL and `cyc_start` = 0.
  - While `enable` = 0, every cycle counts as terminal, so loads apply immediately.
  - On the first `enable` = 1 cycle, `cnt` = 0.
- Arithmetic: all compares are unsigned CNT_W-bit. The counter never overflows because it wraps at P_a ≤ 2^CNT_W−1.

## Timing
- Reset values (cycle after `RESET` sampled low):
  - `cnt` = 0, `dir` = 0.
  - P_a = RST_PERIOD, D_a = 0, M_a = 0.
  - Pending registers = 0, `pend` = 0.
  - `PWM_out` = POL, `cyc_start` = 0, `cfg_pending` = 0.
- Reset dominates `cfg_load` and `enable` in the same cycle.
- Reset mid-period: the counter is abandoned, and the next period starts at 0 once `RESET` is high and `enable` is high.
- Latency: `PWM_out` and `cyc_start` at cycle t+1 reflect `cnt` at cycle t.
- `cfg_pending` is registered: it rises the cycle after `cfg_load` and falls the cycle after the applying terminal cycle.
- New settings first affect the output cycle for count 0 of the next period.
- Edge mode, 0 < D ≤ P: output high for D cycles, then low for P+1−D cycles.
- Center mode: output high for 2·D−1 cycles, centered on count 0, when 0 < D ≤ P.

## Structure
- Package `pwm_pkg`:
  - Type `pwm_mode_t` (EDGE = 0, CENTER = 1).
  - Default constants CNT_W_DEF = 32 and RST_PERIOD_DEF = 9999.
- Sub-module `pwm_timebase`: owns `cnt`, `dir`, the terminal/boundary decode and the shadow-apply strobe.
- Top level: pending/active registers, plus a generate loop of N_CH comparator/output flops.

## Test plan
- Edge mode, P = 9, D = {0, 3, 10, 5}, POL = 0 -> periods of 10 cycles; ch0 always low, ch1 high for 3, ch2 always high, ch3 high for 5; `cyc_start` every 10 cycles.
- Center mode, P = 4, D[0] = 2 -> period 8; ch0 high for 3 cycles per period, centered on the `cyc_start` pulse.
- Mid-period load of P = 19, D[0] = 7 while running P = 9 -> old waveform until the boundary; `cfg_pending` high throughout; new 20-cycle period starts exactly at the next `cyc_start`.
- `cfg_load` in the terminal cycle, plus two back-to-back loads -> the terminal-cycle values apply immediately with `pend` = 0; for back-to-back loads only the second is applied.
- Reset and enable: `RESET` low mid-period with POL = 4'b0101 -> next cycle `PWM_out` = 0101, `cnt` = 0, P_a = 9999; `enable` low -> outputs hold POL and `cyc_start` stays 0.
- Boundary: P = 0 in both modes -> constant output, equal to (D > 0) XOR POL; `cyc_start` high every cycle; CNT_W = 8, P = 255, D = 255 -> high for 255 of 256 cycles.
